// File: rtl/mem_stage_ctrl.sv
`timescale 1ns/1ps
// MEM stage controller: runs one data-memory access per load/store, stalls the
// upstream pipeline while the access is outstanding, and owns the MEM/WB register.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        em_RegWrite,
  input  logic        em_MemRead,
  input  logic        em_MemWrite,
  input  logic [1:0]  em_MemtoReg,
  input  logic [31:0] em_ALUout,
  input  logic [31:0] em_PCjia4,
  input  logic [31:0] em_WriteData,
  input  logic [4:0]  em_WriteAddress,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        wb_RegWrite,
  output logic [1:0]  wb_MemtoReg,
  output logic [4:0]  wb_WriteAddress,
  output logic [31:0] wb_ALUout,
  output logic [31:0] wb_ReadData,
  output logic [31:0] wb_PCjia4,
  output logic        bus_err,
  output logic        misalign_err
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic        wb_RegWrite_q, wb_RegWrite_d;
  logic [1:0]  wb_MemtoReg_q, wb_MemtoReg_d;
  logic [4:0]  wb_WriteAddress_q, wb_WriteAddress_d;
  logic [31:0] wb_ALUout_q, wb_ALUout_d;
  logic [31:0] wb_ReadData_q, wb_ReadData_d;
  logic [31:0] wb_PCjia4_q, wb_PCjia4_d;
  logic        bus_err_q, bus_err_d;
  logic        misalign_err_q, misalign_err_d;

  logic mem_op;
  logic addr_aligned;
  logic cnt_expired;
  logic start_access;
  logic req_wait;
  logic ack_done;
  logic timeout_done;
  logic misalign_hit;

  assign mem_op       = em_MemRead | em_MemWrite;
  assign addr_aligned = (em_ALUout[1:0] == 2'b00);
  assign cnt_expired  = (cnt_q == TIMEOUT_CNT);

  // State register; reset drops an in-flight request immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_op && addr_aligned) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (dm_ack || cnt_expired) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Event decode; stall never looks at dm_rdata.
  always_comb begin
    start_access = 1'b0;
    req_wait     = 1'b0;
    ack_done     = 1'b0;
    timeout_done = 1'b0;
    misalign_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (addr_aligned) begin
            start_access = 1'b1;
          end else begin
            misalign_hit = 1'b1;
          end
        end
      end
      REQ: begin
        if (dm_ack) begin
          ack_done = 1'b1;
        end else if (cnt_expired) begin
          timeout_done = 1'b1;
        end else begin
          req_wait = 1'b1;
        end
      end
      default: begin
        start_access = 1'b0;
      end
    endcase
  end

  assign stall = start_access | req_wait;

  always_comb begin
    cnt_d      = cnt_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    if (start_access) begin
      cnt_d      = 8'd0;
      dm_req_d   = 1'b1;
      dm_we_d    = em_MemWrite;
      dm_addr_d  = {em_ALUout[31:2], 2'b00};
      dm_wdata_d = em_WriteData;
    end else if (req_wait) begin
      cnt_d = cnt_q + 8'd1;
    end else if (ack_done || timeout_done) begin
      cnt_d    = 8'd0;
      dm_req_d = 1'b0;
      dm_we_d  = 1'b0;
    end
  end

  // MEM/WB: bubbles while stalled; a failed access still advances but never writes back.
  always_comb begin
    wb_RegWrite_d     = wb_RegWrite_q;
    wb_MemtoReg_d     = wb_MemtoReg_q;
    wb_WriteAddress_d = wb_WriteAddress_q;
    wb_ALUout_d       = wb_ALUout_q;
    wb_ReadData_d     = wb_ReadData_q;
    wb_PCjia4_d       = wb_PCjia4_q;
    bus_err_d         = bus_err_q | timeout_done;
    misalign_err_d    = misalign_err_q | misalign_hit;
    if (stall) begin
      wb_RegWrite_d     = 1'b0;
      wb_MemtoReg_d     = 2'b00;
      wb_WriteAddress_d = 5'd0;
    end else begin
      wb_RegWrite_d     = em_RegWrite & ~(misalign_hit | timeout_done);
      wb_MemtoReg_d     = em_MemtoReg;
      wb_WriteAddress_d = em_WriteAddress;
      wb_ALUout_d       = em_ALUout;
      wb_PCjia4_d       = em_PCjia4;
      if (ack_done && !dm_we_q) begin
        wb_ReadData_d = dm_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q             <= 8'd0;
      dm_req_q          <= 1'b0;
      dm_we_q           <= 1'b0;
      dm_addr_q         <= 32'd0;
      dm_wdata_q        <= 32'd0;
      wb_RegWrite_q     <= 1'b0;
      wb_MemtoReg_q     <= 2'b00;
      wb_WriteAddress_q <= 5'd0;
      wb_ALUout_q       <= 32'd0;
      wb_ReadData_q     <= 32'd0;
      wb_PCjia4_q       <= 32'd0;
      bus_err_q         <= 1'b0;
      misalign_err_q    <= 1'b0;
    end else begin
      cnt_q             <= cnt_d;
      dm_req_q          <= dm_req_d;
      dm_we_q           <= dm_we_d;
      dm_addr_q         <= dm_addr_d;
      dm_wdata_q        <= dm_wdata_d;
      wb_RegWrite_q     <= wb_RegWrite_d;
      wb_MemtoReg_q     <= wb_MemtoReg_d;
      wb_WriteAddress_q <= wb_WriteAddress_d;
      wb_ALUout_q       <= wb_ALUout_d;
      wb_ReadData_q     <= wb_ReadData_d;
      wb_PCjia4_q       <= wb_PCjia4_d;
      bus_err_q         <= bus_err_d;
      misalign_err_q    <= misalign_err_d;
    end
  end

  assign dm_req          = dm_req_q;
  assign dm_we           = dm_we_q;
  assign dm_addr         = dm_addr_q;
  assign dm_wdata        = dm_wdata_q;
  assign wb_RegWrite     = wb_RegWrite_q;
  assign wb_MemtoReg     = wb_MemtoReg_q;
  assign wb_WriteAddress = wb_WriteAddress_q;
  assign wb_ALUout       = wb_ALUout_q;
  assign wb_ReadData     = wb_ReadData_q;
  assign wb_PCjia4       = wb_PCjia4_q;
  assign bus_err         = bus_err_q;
  assign misalign_err    = misalign_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_stage_ctrl: the driver pushes expected write-backs and
// memory accesses, a monitor pops and compares them as the DUT presents them.
module tb_mem_stage_ctrl;

  localparam int TB_TIMEOUT = 255;

  typedef struct packed {
    logic        rw;
    logic        mr;
    logic        mw;
    logic [1:0]  mtr;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] wd;
    logic [4:0]  wa;
  } instr_t;

  typedef struct {
    logic [4:0]  wa;
    logic [1:0]  mtr;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } dm_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        em_RegWrite, em_MemRead, em_MemWrite;
  logic [1:0]  em_MemtoReg;
  logic [31:0] em_ALUout, em_PCjia4, em_WriteData;
  logic [4:0]  em_WriteAddress;
  logic        stall, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ack;
  logic        wb_RegWrite;
  logic [1:0]  wb_MemtoReg;
  logic [4:0]  wb_WriteAddress;
  logic [31:0] wb_ALUout, wb_ReadData, wb_PCjia4;
  logic        bus_err, misalign_err;

  int tests_run = 0;
  int failures  = 0;

  wb_exp_t wb_q[$];
  dm_exp_t dm_q[$];

  // responder configuration and bench-side model state
  int          ack_on   = 1;
  bit          idle_ack = 1'b0;
  logic [31:0] rd_val   = 32'd0;
  logic [31:0] model_rdata = 32'd0;
  bit          model_bus = 1'b0;
  bit          model_mis = 1'b0;
  int          last_gap  = 0;

  mem_stage_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .em_RegWrite(em_RegWrite), .em_MemRead(em_MemRead), .em_MemWrite(em_MemWrite),
    .em_MemtoReg(em_MemtoReg), .em_ALUout(em_ALUout), .em_PCjia4(em_PCjia4),
    .em_WriteData(em_WriteData), .em_WriteAddress(em_WriteAddress),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_WriteAddress(wb_WriteAddress),
    .wb_ALUout(wb_ALUout), .wb_ReadData(wb_ReadData), .wb_PCjia4(wb_PCjia4),
    .bus_err(bus_err), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic rw, input logic mr, input logic mw,
                                input logic [1:0] mtr, input logic [31:0] alu,
                                input logic [31:0] pc4, input logic [31:0] wd,
                                input logic [4:0] wa);
    instr_t r;
    r.rw = rw; r.mr = mr; r.mw = mw; r.mtr = mtr;
    r.alu = alu; r.pc4 = pc4; r.wd = wd; r.wa = wa;
    return r;
  endfunction

  task automatic drive(input instr_t ins);
    em_RegWrite     = ins.rw;
    em_MemRead      = ins.mr;
    em_MemWrite     = ins.mw;
    em_MemtoReg     = ins.mtr;
    em_ALUout       = ins.alu;
    em_PCjia4       = ins.pc4;
    em_WriteData    = ins.wd;
    em_WriteAddress = ins.wa;
  endtask

  // Issue one instruction, hold it until the DUT stops stalling, then check side effects.
  task automatic applyStimulus(input instr_t ins, input int ack, input logic [31:0] rd,
                               input int exp_stall, input bit idle_ack_i);
    bit      writes, mem_op, aligned, s, done, bubble_checked;
    int      stalls;
    wb_exp_t we;
    dm_exp_t de;
    mem_op  = ins.mr | ins.mw;
    aligned = (ins.alu[1:0] == 2'b00);
    writes  = ins.rw;
    if (mem_op && !aligned) begin
      writes    = 1'b0;
      model_mis = 1'b1;
    end else if (mem_op) begin
      de.we = ins.mw; de.addr = ins.alu; de.wdata = ins.wd;
      de.len = (ack == 0) ? TB_TIMEOUT + 1 : ack;
      dm_q.push_back(de);
      if (ack == 0) begin
        writes    = 1'b0;
        model_bus = 1'b1;
      end else if (!ins.mw) begin
        model_rdata = rd;
      end
    end
    if (writes) begin
      we.wa = ins.wa; we.mtr = ins.mtr; we.alu = ins.alu; we.pc4 = ins.pc4; we.rdata = model_rdata;
      wb_q.push_back(we);
    end
    ack_on   = ack;
    rd_val   = rd;
    idle_ack = idle_ack_i;
    @(negedge clk);
    drive(ins);
    stalls = 0;
    done = 1'b0;
    bubble_checked = 1'b0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (stalls > 0 && !bubble_checked) begin
        checkOutput("bubble", 64'({wb_RegWrite, wb_MemtoReg, wb_WriteAddress}), 64'd0);
        bubble_checked = 1'b1;
      end
      s = stall;
      @(posedge clk);
      if (!s) begin
        done = 1'b1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    checkOutput("accepted", 64'(done), 64'd1);
    checkOutput("stall_cycles", 64'(stalls), 64'(exp_stall));
    #1;
    checkOutput("dm_req_after", 64'(dm_req), 64'd0);
    checkOutput("misalign_err", 64'(misalign_err), 64'(model_mis));
    checkOutput("bus_err", 64'(bus_err), 64'(model_bus));
    if (!writes) checkOutput("no_writeback", 64'(wb_RegWrite), 64'd0);
  endtask

  // Memory responder: acks on the ack_on-th cycle of a request (0 = never).
  initial begin
    int req_cyc;
    req_cyc  = 0;
    dm_ack   = 1'b0;
    dm_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (dm_req) begin
        req_cyc++;
        dm_ack   = (req_cyc == ack_on);
        dm_rdata = dm_ack ? rd_val : (32'hBAD0_0000 ^ 32'(req_cyc));
      end else begin
        req_cyc  = 0;
        dm_ack   = idle_ack;
        dm_rdata = 32'h0BAD_F00D;
      end
    end
  end

  // Monitor: compares write-backs and memory requests against the scoreboard queues.
  initial begin
    bit      prev_req;
    int      req_len, gap, len_exp;
    wb_exp_t e;
    dm_exp_t d;
    prev_req = 1'b0; req_len = 0; gap = 1000; len_exp = 0;
    forever begin
      @(negedge clk);
      if (wb_RegWrite === 1'b1) begin
        if (wb_q.size() == 0) begin
          checkOutput("wb_unexpected", 64'd1, 64'd0);
        end else begin
          e = wb_q.pop_front();
          checkOutput("wb_WriteAddress", 64'(wb_WriteAddress), 64'(e.wa));
          checkOutput("wb_MemtoReg", 64'(wb_MemtoReg), 64'(e.mtr));
          checkOutput("wb_ALUout", 64'(wb_ALUout), 64'(e.alu));
          checkOutput("wb_PCjia4", 64'(wb_PCjia4), 64'(e.pc4));
          checkOutput("wb_ReadData", 64'(wb_ReadData), 64'(e.rdata));
        end
      end
      if (dm_req && !prev_req) begin
        last_gap = gap;
        req_len  = 1;
        if (dm_q.size() == 0) begin
          checkOutput("dm_unexpected", 64'd1, 64'd0);
          len_exp = 0;
        end else begin
          d = dm_q.pop_front();
          checkOutput("dm_we", 64'(dm_we), 64'(d.we));
          checkOutput("dm_addr", 64'(dm_addr), 64'(d.addr));
          checkOutput("dm_wdata", 64'(dm_wdata), 64'(d.wdata));
          len_exp = d.len;
        end
      end else if (dm_req) begin
        req_len++;
      end else if (prev_req) begin
        checkOutput("dm_req_len", 64'(req_len), 64'(len_exp));
        gap = 1;
      end else begin
        gap++;
      end
      prev_req = dm_req;
    end
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    dm_exp_t de;
    reset = 1'b1;
    drive(mk(0, 0, 0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0));
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_stall", 64'(stall), 64'd0);
    checkOutput("rst_dm_ctrl", 64'({dm_req, dm_we}), 64'd0);
    checkOutput("rst_dm_addr", 64'(dm_addr), 64'd0);
    checkOutput("rst_dm_wdata", 64'(dm_wdata), 64'd0);
    checkOutput("rst_wb_ctrl", 64'({wb_RegWrite, wb_MemtoReg, wb_WriteAddress}), 64'd0);
    checkOutput("rst_wb_data", 64'({wb_ALUout, wb_ReadData}), 64'd0);
    checkOutput("rst_wb_pc", 64'(wb_PCjia4), 64'd0);
    checkOutput("rst_errs", 64'({bus_err, misalign_err}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(mk(1, 0, 0, 2'd0, 32'h1234, 32'h1004, 32'd0, 5'd5), 1, 32'd0, 0, 1'b0);
    applyStimulus(mk(1, 1, 0, 2'd1, 32'h100, 32'h1008, 32'd0, 5'd7), 3, 32'hDEADBEEF, 3, 1'b0);
    applyStimulus(mk(1, 0, 0, 2'd0, 32'h55, 32'h100C, 32'd0, 5'd3), 1, 32'd0, 0, 1'b0);
    applyStimulus(mk(0, 0, 1, 2'd0, 32'h200, 32'h1010, 32'hA5A5A5A5, 5'd0), 1, 32'd0, 1, 1'b0);
    applyStimulus(mk(1, 1, 0, 2'd1, 32'h204, 32'h1014, 32'd0, 5'd10), 1, 32'h13579BDF, 1, 1'b0);
    checkOutput("req_gap", 64'(last_gap), 64'd1);
    applyStimulus(mk(0, 1, 1, 2'd0, 32'h208, 32'h1018, 32'h0F0F0F0F, 5'd0), 2, 32'hFFFF0000, 2, 1'b0);
    applyStimulus(mk(1, 0, 0, 2'd2, 32'h77, 32'h101C, 32'd0, 5'd4), 1, 32'd0, 0, 1'b1);
    applyStimulus(mk(1, 1, 0, 2'd1, 32'h40, 32'h1020, 32'd0, 5'd12), 2, 32'hCAFEF00D, 2, 1'b1);
    applyStimulus(mk(1, 1, 0, 2'd1, 32'h103, 32'h1024, 32'd0, 5'd13), 1, 32'd0, 0, 1'b0);
    applyStimulus(mk(0, 0, 1, 2'd0, 32'h202, 32'h1028, 32'h1, 5'd0), 1, 32'd0, 0, 1'b0);
    applyStimulus(mk(1, 1, 0, 2'd1, 32'h400, 32'h102C, 32'd0, 5'd14), 0, 32'd0, 256, 1'b0);
    applyStimulus(mk(1, 0, 0, 2'd0, 32'h99, 32'h1030, 32'd0, 5'd15), 1, 32'd0, 0, 1'b0);

    // reset in the second request cycle aborts the load with no write-back
    de.we = 1'b0; de.addr = 32'h300; de.wdata = 32'h0; de.len = 2;
    dm_q.push_back(de);
    ack_on = 0;
    idle_ack = 1'b0;
    @(negedge clk);
    drive(mk(1, 1, 0, 2'd1, 32'h300, 32'h1034, 32'h0, 5'd9));
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_dm_req", 64'(dm_req), 64'd0);
    checkOutput("abort_wb_ctrl", 64'({wb_RegWrite, wb_MemtoReg, wb_WriteAddress}), 64'd0);
    checkOutput("abort_wb_data", 64'({wb_ALUout, wb_ReadData}), 64'd0);
    checkOutput("abort_wb_pc", 64'(wb_PCjia4), 64'd0);
    checkOutput("abort_errs", 64'({bus_err, misalign_err}), 64'd0);
    drive(mk(0, 0, 0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0));
    #1;
    checkOutput("abort_idle_stall", 64'(stall), 64'd0);
    model_rdata = 32'd0;
    model_bus   = 1'b0;
    model_mis   = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(mk(1, 0, 0, 2'd0, 32'hAB, 32'h2000, 32'd0, 5'd6), 1, 32'd0, 0, 1'b0);
    applyStimulus(mk(1, 1, 0, 2'd1, 32'h500, 32'h2004, 32'd0, 5'd8), 1, 32'h600D600D, 1, 1'b0);
    applyStimulus(mk(0, 0, 0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0), 1, 32'd0, 0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    checkOutput("dm_queue_drained", 64'(dm_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock for all state and output registers.
REQ-002 reset  in  1  asynchronous, active-high; clears all state and registered outputs.
REQ-003 em_RegWrite, em_MemRead, em_MemWrite  in  1 each  control bits from the EX/MEM register.
REQ-004 em_MemtoReg  in  2  write-back select from EX/MEM.
REQ-005 em_ALUout, em_PCjia4, em_WriteData  in  32 each  ALU result/address, PC+4, store data from EX/MEM.
REQ-006 em_WriteAddress  in  5  destination register from EX/MEM.
REQ-007 stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-008 dm_req, dm_we  out  1 each  registered data-memory request and write enable.
REQ-009 dm_addr, dm_wdata  out  32 each  registered address (word-aligned) and write data.
REQ-010 dm_rdata  in  32  read data, valid when dm_ack high; dm_ack  in  1  access complete.
REQ-011 wb_RegWrite  out  1; wb_MemtoReg  out  2; wb_WriteAddress  out  5  registered MEM/WB controls.
REQ-012 wb_ALUout, wb_ReadData, wb_PCjia4  out  32 each  registered MEM/WB data.
REQ-013 bus_err, misalign_err  out  1 each  sticky error flags, cleared only by reset.
REQ-014 Parameter TIMEOUT, default 255, cycles in REQ without dm_ack before forced completion.

Function
REQ-015 mem_op = em_MemRead | em_MemWrite; both high = store (write performed, read ignored).
REQ-016 FSM states IDLE, REQ; 8-bit wait counter cnt.
REQ-017 IDLE, mem_op=0: stall=0; MEM/WB regs load em_* fields at the edge, wb_ReadData holds; latency 1 cycle.
REQ-018 IDLE, mem_op=1, em_ALUout[1:0]=0: stall=1; at edge -> REQ, dm_req<=1, dm_we<=em_MemWrite, dm_addr<=em_ALUout, dm_wdata<=em_WriteData, cnt<=0.
REQ-019 IDLE, mem_op=1, em_ALUout[1:0]!=0: no access, stall=0, misalign_err<=1, MEM/WB loads with wb_RegWrite<=0.
REQ-020 REQ, dm_ack=0: stall=1, cnt increments, dm_* hold.
REQ-021 REQ, dm_ack=1: stall=0 this cycle; at edge -> IDLE, dm_req<=0, dm_we<=0, MEM/WB loads em_* fields, wb_ReadData<=dm_rdata for reads (holds for stores).
REQ-022 REQ, dm_ack=0, cnt=TIMEOUT: stall=0; at edge -> IDLE, dm_req<=0, bus_err<=1, MEM/WB loads with wb_RegWrite<=0.
REQ-023 While stall=1, MEM/WB loads bubble at each edge: wb_RegWrite<=0, wb_MemtoReg<=0, wb_WriteAddress<=0, other wb_* hold.
REQ-024 dm_req is low for at least one cycle between consecutive accesses (IDLE never drives it high); back-to-back memory op minimum 2 cycles each.
REQ-025 dm_ack while in IDLE is ignored.
REQ-026 stall depends only on state, mem_op, em_ALUout[1:0], dm_ack, cnt; no combinational path from dm_rdata.

Reset
REQ-027 On reset: state IDLE, cnt=0, dm_req=dm_we=0, dm_addr=dm_wdata=0, all wb_* = 0, bus_err=misalign_err=0; stall then follows REQ-017..019.
REQ-028 Reset during REQ aborts the access immediately (dm_req low asynchronously); no MEM/WB update from the aborted op.

Verification
REQ-029 Non-mem: em_RegWrite=1, em_ALUout=0x1234, em_WriteAddress=5 -> stall=0, next cycle wb_RegWrite=1, wb_ALUout=0x1234, wb_WriteAddress=5.
REQ-030 Load addr 0x100, dm_ack on 3rd REQ cycle, dm_rdata=0xDEADBEEF -> stall high 3 cycles, dm_req high 3 cycles, wb_ReadData=0xDEADBEEF, bubbles (wb_RegWrite=0) during stall.
REQ-031 Store 0x200 data 0xA5A5A5A5, then load 0x204 back-to-back, immediate ack -> dm_we=1 then 0, dm_req low one cycle between accesses.
REQ-032 Load 0x103 -> no dm_req, misalign_err=1, wb_RegWrite=0, stall=0.
REQ-033 Load, dm_ack never -> after TIMEOUT+1 REQ cycles stall drops, bus_err=1, wb_RegWrite=0; flag holds until reset.
REQ-034 Assert reset in REQ cycle 2 -> dm_req=0 at once, all wb_*=0, state IDLE, no write-back.
